// File: rtl/data_buffer_arbiter.sv
// Pointer/occupancy owner for the shared USB endpoint buffer; arbitrates the single
// write port (RX vs AHB) and single read port (TX vs AHB) with AHB starvation relief.
module data_buffer_arbiter #(
   parameter int unsigned DEPTH        = 64,
   parameter int unsigned STARVE_LIMIT = 4,
   localparam int unsigned AW          = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          clear,
   input  logic          lock_db,
   input  logic          rx_wr_req,
   input  logic [7:0]    rx_wr_data,
   input  logic          tx_rd_req,
   input  logic          ahb_wr_req,
   input  logic [7:0]    ahb_wdata,
   input  logic          ahb_rd_req,
   input  logic [7:0]    mem_rdata,
   output logic          rx_wr_gnt,
   output logic          ahb_wr_gnt,
   output logic          tx_rd_gnt,
   output logic          ahb_rd_gnt,
   output logic          mem_we,
   output logic [AW-1:0] mem_waddr,
   output logic [7:0]    mem_wdata,
   output logic          mem_re,
   output logic [AW-1:0] mem_raddr,
   output logic [7:0]    rd_data,
   output logic          tx_rd_valid,
   output logic          ahb_rd_valid,
   output logic [AW:0]   buffer_occupancy,
   output logic          overflow_err,
   output logic          underflow_err
);

   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_occ;
   logic [SW-1:0] r_wstarve;
   logic [SW-1:0] r_rstarve;
   logic          r_tx_valid;
   logic          r_ahb_valid;
   logic          r_ovf;
   logic          r_unf;

   logic w_full;
   logic w_empty;
   logic w_rx_elig;
   logic w_tx_elig;
   logic w_ahb_wforce;
   logic w_ahb_rforce;
   logic w_wr_commit;
   logic w_rd_commit;

   assign w_full  = (r_occ == (AW+1)'(DEPTH));
   assign w_empty = (r_occ == '0);

   // Grants: clear blocks everything; starvation override beats USB priority
   always_comb begin
      rx_wr_gnt    = 1'b0;
      ahb_wr_gnt   = 1'b0;
      tx_rd_gnt    = 1'b0;
      ahb_rd_gnt   = 1'b0;
      w_rx_elig    = !lock_db && !w_full;
      w_tx_elig    = !lock_db && !w_empty;
      w_ahb_wforce = ahb_wr_req && !w_full  && (r_wstarve == SW'(STARVE_LIMIT));
      w_ahb_rforce = ahb_rd_req && !w_empty && (r_rstarve == SW'(STARVE_LIMIT));
      if (!clear) begin
         rx_wr_gnt  = rx_wr_req && w_rx_elig && !w_ahb_wforce;
         ahb_wr_gnt = ahb_wr_req && !w_full && !rx_wr_gnt;
         tx_rd_gnt  = tx_rd_req && w_tx_elig && !w_ahb_rforce;
         ahb_rd_gnt = ahb_rd_req && !w_empty && !tx_rd_gnt;
      end
      w_wr_commit = rx_wr_gnt || ahb_wr_gnt;
      w_rd_commit = tx_rd_gnt || ahb_rd_gnt;
   end

   assign mem_we           = w_wr_commit;
   assign mem_re           = w_rd_commit;
   assign mem_waddr        = r_wptr;
   assign mem_raddr        = r_rptr;
   assign mem_wdata        = rx_wr_gnt ? rx_wr_data : ahb_wdata;
   assign rd_data          = mem_rdata;
   assign tx_rd_valid      = r_tx_valid;
   assign ahb_rd_valid     = r_ahb_valid;
   assign buffer_occupancy = r_occ;
   assign overflow_err     = r_ovf;
   assign underflow_err    = r_unf;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_occ       <= '0;
         r_wstarve   <= '0;
         r_rstarve   <= '0;
         r_tx_valid  <= 1'b0;
         r_ahb_valid <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
      end else begin
         r_tx_valid  <= tx_rd_gnt;
         r_ahb_valid <= ahb_rd_gnt;
         r_ovf       <= !clear && !lock_db && rx_wr_req && w_full;
         r_unf       <= !clear && !lock_db && tx_rd_req && w_empty;
         if (clear) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
         end else begin
            if (w_wr_commit) r_wptr <= r_wptr + AW'(1);
            if (w_rd_commit) r_rptr <= r_rptr + AW'(1);
            unique case ({w_wr_commit, w_rd_commit})
               2'b10:   r_occ <= r_occ + (AW+1)'(1);
               2'b01:   r_occ <= r_occ - (AW+1)'(1);
               default: r_occ <= r_occ;
            endcase
         end
         // Starvation counters only advance when AHB was eligible and lost to USB
         if (clear || ahb_wr_gnt || !ahb_wr_req)
            r_wstarve <= '0;
         else if (rx_wr_gnt && (r_wstarve != SW'(STARVE_LIMIT)))
            r_wstarve <= r_wstarve + SW'(1);
         if (clear || ahb_rd_gnt || !ahb_rd_req)
            r_rstarve <= '0;
         else if (tx_rd_gnt && (r_rstarve != SW'(STARVE_LIMIT)))
            r_rstarve <= r_rstarve + SW'(1);
      end
   end

endmodule

// File: tb/tb_data_buffer_arbiter.sv
// Directed bench for data_buffer_arbiter: fill/drain, errors, lock, clear,
// starvation relief and asynchronous reset, against a behavioural buffer RAM.
module tb_data_buffer_arbiter;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          clear, lock_db;
   logic          rx_wr_req, tx_rd_req, ahb_wr_req, ahb_rd_req;
   logic [7:0]    rx_wr_data, ahb_wdata, mem_rdata;
   logic          rx_wr_gnt, ahb_wr_gnt, tx_rd_gnt, ahb_rd_gnt;
   logic          mem_we, mem_re;
   logic [AW-1:0] mem_waddr, mem_raddr;
   logic [7:0]    mem_wdata, rd_data;
   logic          tx_rd_valid, ahb_rd_valid;
   logic [AW:0]   buffer_occupancy;
   logic          overflow_err, underflow_err;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_buffer_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(4)) dut (
      .clk(clk), .n_rst(n_rst), .clear(clear), .lock_db(lock_db),
      .rx_wr_req(rx_wr_req), .rx_wr_data(rx_wr_data), .tx_rd_req(tx_rd_req),
      .ahb_wr_req(ahb_wr_req), .ahb_wdata(ahb_wdata), .ahb_rd_req(ahb_rd_req),
      .mem_rdata(mem_rdata),
      .rx_wr_gnt(rx_wr_gnt), .ahb_wr_gnt(ahb_wr_gnt), .tx_rd_gnt(tx_rd_gnt),
      .ahb_rd_gnt(ahb_rd_gnt), .mem_we(mem_we), .mem_waddr(mem_waddr),
      .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_raddr(mem_raddr),
      .rd_data(rd_data), .tx_rd_valid(tx_rd_valid), .ahb_rd_valid(ahb_rd_valid),
      .buffer_occupancy(buffer_occupancy), .overflow_err(overflow_err),
      .underflow_err(underflow_err)
   );

   // Buffer RAM: registered read, one cycle after mem_re
   logic [7:0] mem [DEPTH];
   always @(posedge clk) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_raddr];
   end

   typedef struct packed {
      logic       clr, lock, rx, tx, aw, ar;
      logic [7:0] rxd, awd;
      logic [3:0] gnt;   // {rx_wr, ahb_wr, tx_rd, ahb_rd}
      logic [6:0] occ;
      logic       ovf, unf, txv, arv, chk;
      logic [7:0] rd;
   } vec_t;

   function automatic vec_t row(logic clr, logic lock, logic rx, logic [7:0] rxd,
                                logic tx, logic aw, logic [7:0] awd, logic ar,
                                logic [3:0] gnt, logic [6:0] occ, logic ovf, logic unf,
                                logic txv, logic arv, logic chk, logic [7:0] rd);
      vec_t v;
      v.clr = clr; v.lock = lock; v.rx = rx; v.rxd = rxd; v.tx = tx;
      v.aw = aw; v.awd = awd; v.ar = ar; v.gnt = gnt; v.occ = occ;
      v.ovf = ovf; v.unf = unf; v.txv = txv; v.arv = arv; v.chk = chk; v.rd = rd;
      return v;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // One cycle: drive, check combinational grants, then registered results after the edge
   task automatic apply(input vec_t v, input string nm);
      clear = v.clr; lock_db = v.lock;
      rx_wr_req = v.rx; rx_wr_data = v.rxd; tx_rd_req = v.tx;
      ahb_wr_req = v.aw; ahb_wdata = v.awd; ahb_rd_req = v.ar;
      #1;
      check({nm, " gnt"}, 32'({rx_wr_gnt, ahb_wr_gnt, tx_rd_gnt, ahb_rd_gnt}), 32'(v.gnt));
      check({nm, " mem_we"}, 32'(mem_we), 32'(v.gnt[3] | v.gnt[2]));
      check({nm, " mem_re"}, 32'(mem_re), 32'(v.gnt[1] | v.gnt[0]));
      if (v.gnt[3])      check({nm, " wdata"}, 32'(mem_wdata), 32'(v.rxd));
      else if (v.gnt[2]) check({nm, " wdata"}, 32'(mem_wdata), 32'(v.awd));
      @(posedge clk); #1;
      check({nm, " occ"}, 32'(buffer_occupancy), 32'(v.occ));
      check({nm, " ovf"}, 32'(overflow_err), 32'(v.ovf));
      check({nm, " unf"}, 32'(underflow_err), 32'(v.unf));
      check({nm, " txv"}, 32'(tx_rd_valid), 32'(v.txv));
      check({nm, " ahbv"}, 32'(ahb_rd_valid), 32'(v.arv));
      if (v.chk) check({nm, " rd_data"}, 32'(rd_data), 32'(v.rd));
   endtask

   vec_t tbl [15];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // After clear at pointer 0: A0,A1,A2 at 0..2, 0x11 at 3, 0x33 at 4, 0x44 at 5, 0x55 at 6
      //              clr lk rx rxd    tx aw awd    ar gnt      occ ovf unf txv arv chk rd
      tbl[0]  = row(0, 0, 1, 8'hA0, 0, 0, 8'h00, 0, 4'b1000, 1, 0, 0, 0, 0, 0, 8'h00);
      tbl[1]  = row(0, 0, 1, 8'hA1, 0, 0, 8'h00, 0, 4'b1000, 2, 0, 0, 0, 0, 0, 8'h00);
      tbl[2]  = row(0, 0, 1, 8'hA2, 0, 0, 8'h00, 0, 4'b1000, 3, 0, 0, 0, 0, 0, 8'h00);
      tbl[3]  = row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0010, 2, 0, 0, 1, 0, 1, 8'hA0);
      tbl[4]  = row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0010, 1, 0, 0, 1, 0, 1, 8'hA1);
      tbl[5]  = row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0010, 0, 0, 0, 1, 0, 1, 8'hA2);
      tbl[6]  = row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 8'h00);
      tbl[7]  = row(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 8'h00);
      tbl[8]  = row(0, 1, 0, 8'h00, 0, 1, 8'h11, 0, 4'b0100, 1, 0, 0, 0, 0, 0, 8'h00);
      tbl[9]  = row(0, 1, 1, 8'h22, 0, 0, 8'h00, 1, 4'b0001, 0, 0, 0, 0, 1, 1, 8'h11);
      tbl[10] = row(0, 1, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 8'h00);
      tbl[11] = row(0, 0, 1, 8'h33, 0, 0, 8'h00, 1, 4'b1000, 1, 0, 0, 0, 0, 0, 8'h00);
      tbl[12] = row(0, 0, 1, 8'h44, 1, 0, 8'h00, 0, 4'b1010, 1, 0, 0, 1, 0, 1, 8'h33);
      tbl[13] = row(0, 0, 1, 8'h55, 0, 1, 8'h66, 0, 4'b1000, 2, 0, 0, 0, 0, 0, 8'h00);
      tbl[14] = row(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 4'b0000, 2, 0, 0, 0, 0, 0, 8'h00);

      n_rst = 1'b0; clear = 1'b0; lock_db = 1'b0;
      rx_wr_req = 1'b0; tx_rd_req = 1'b0; ahb_wr_req = 1'b0; ahb_rd_req = 1'b0;
      rx_wr_data = '0; ahb_wdata = '0;
      #2;
      check("reset occ", 32'(buffer_occupancy), 32'd0);
      check("reset errs", 32'({overflow_err, underflow_err}), 32'd0);
      check("reset valids", 32'({tx_rd_valid, ahb_rd_valid}), 32'd0);
      check("reset gnts", 32'({rx_wr_gnt, ahb_wr_gnt, tx_rd_gnt, ahb_rd_gnt}), 32'd0);
      check("reset ptrs", 32'({mem_waddr, mem_raddr}), 32'd0);
      #10 n_rst = 1'b1;
      @(posedge clk); #1;

      // Fill to DEPTH, then two overflow attempts
      for (int i = 0; i < 64; i++)
         apply(row(0, 0, 1, 8'(i), 0, 0, 8'h00, 0, 4'b1000, 7'(i + 1), 0, 0, 0, 0, 0, 8'h00),
               $sformatf("fill%0d", i));
      check("wptr wrap", 32'(mem_waddr), 32'd0);
      apply(row(0, 0, 1, 8'hEE, 0, 0, 8'h00, 0, 4'b0000, 64, 1, 0, 0, 0, 0, 8'h00), "ovf0");
      apply(row(0, 0, 1, 8'hEE, 0, 0, 8'h00, 0, 4'b0000, 64, 1, 0, 0, 0, 0, 8'h00), "ovf1");

      // Drain all, checking data order, then one underflow attempt
      for (int i = 0; i < 64; i++)
         apply(row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0010, 7'(63 - i), 0, 0, 1, 0, 1, 8'(i)),
               $sformatf("drain%0d", i));
      check("rptr wrap", 32'(mem_raddr), 32'd0);
      apply(row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 8'h00), "unf");

      // Partial fill, then clear with every request active
      for (int i = 0; i < 5; i++)
         apply(row(0, 0, 1, 8'(i), 0, 0, 8'h00, 0, 4'b1000, 7'(i + 1), 0, 0, 0, 0, 0, 8'h00),
               $sformatf("pre%0d", i));
      apply(row(1, 0, 1, 8'hCC, 1, 1, 8'hDD, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 8'h00), "clear");
      check("clear wptr", 32'(mem_waddr), 32'd0);
      check("clear rptr", 32'(mem_raddr), 32'd0);

      for (int i = 0; i < 15; i++) apply(tbl[i], $sformatf("vec%0d", i));

      // RX and AHB writes held together: AHB forced through every fifth cycle
      for (int k = 0; k < 10; k++)
         apply(row(0, 0, 1, 8'(8'h70 + k), 0, 1, 8'(8'h90 + k), 0,
                   (k == 4 || k == 9) ? 4'b0100 : 4'b1000, 7'(k + 3), 0, 0, 0, 0, 0, 8'h00),
               $sformatf("starve%0d", k));

      // Asynchronous reset with a read-valid in flight
      apply(row(0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 4'b0010, 11, 0, 0, 1, 0, 0, 8'h00), "inflight");
      n_rst = 1'b0;
      #1;
      check("mid-reset txv", 32'(tx_rd_valid), 32'd0);
      check("mid-reset occ", 32'(buffer_occupancy), 32'd0);
      check("mid-reset rptr", 32'(mem_raddr), 32'd0);
      tx_rd_req = 1'b0;
      #2 n_rst = 1'b1;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
